// File: rtl/adc_pkg.sv
// Shared constants and types for the serial ADC reader.
package adc_pkg;

    localparam int ADC_W = 8;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } adc_state_t;

    // One frame = CS_n-high wait + setup half-period + 2*ADC_W half-periods + DONE.
    function automatic int frame_len(input int conv_wait, input int clk_div);
        return conv_wait + (2 * ADC_W + 1) * clk_div + 1;
    endfunction

    localparam int FRAME_LEN_DEFAULT = frame_len(1000, 25);

endpackage

// File: rtl/adc_serial_reader_if.sv
// ADC pin and result bundle; master = reader, slave = ADC/consumer side.
interface adc_serial_reader_if;
    import adc_pkg::*;

    logic             adc_sdo;
    logic             adc_cs_n;
    logic             adc_sclk;
    logic [ADC_W-1:0] adc_data;
    logic             data_valid;
    logic             busy;

    modport master (
        input  adc_sdo,
        output adc_cs_n,
        output adc_sclk,
        output adc_data,
        output data_valid,
        output busy
    );

    modport slave (
        output adc_sdo,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_data,
        input  data_valid,
        input  busy
    );

endinterface

// File: rtl/adc_avg4.sv
// Running average of the last four conversions (10-bit sum, truncated >> 2).
module adc_avg4
    import adc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] raw_data,
    input  logic             raw_stb,
    output logic [ADC_W-1:0] avg_data,
    output logic             avg_stb
);

    localparam int SUM_W = ADC_W + 2;

    logic [3:0][ADC_W-1:0] hist;
    logic [SUM_W-1:0]      sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            avg_stb <= 1'b0;
        end else begin
            avg_stb <= raw_stb;
            if (raw_stb) begin
                hist <= {hist[2:0], raw_data};
            end
        end
    end

    // Sum is taken from registered history, so the output only moves with avg_stb.
    assign sum = SUM_W'(hist[0]) + SUM_W'(hist[1]) + SUM_W'(hist[2]) + SUM_W'(hist[3]);
    assign avg_data = ADC_W'(sum >> 2);

endmodule

// File: rtl/adc_serial_reader.sv
// Free-running TLC549-style serial ADC reader; latest conversion held on adc_data.
// Optional 4-sample averaging on the output when ADC_AVG4_EN is defined.
//
// state | meaning
// WAIT  | CS_n high, ADC converting, count CONV_WAIT cycles
// SETUP | CS_n low, SCLK low for CLK_DIV cycles while ADC drives MSB
// SHIFT | ADC_W SCLK periods, sample on each SCLK rising edge
// DONE  | CS_n high, latch shift register into the result register
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = 25,
    parameter int CONV_WAIT = 1000
)
(
    input  logic               clk,
    input  logic               reset,
    adc_serial_reader_if.master bus
);

    localparam int CNT_MAX = (CONV_WAIT > CLK_DIV) ? CONV_WAIT : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(ADC_W);

    localparam logic [CNT_W-1:0] WAIT_TC  = CNT_W'(CONV_WAIT - 1);
    localparam logic [CNT_W-1:0] DIV_TC   = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ADC_W - 1);

    adc_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [ADC_W-1:0] shreg, shreg_nxt;
    logic             sclk_q, sclk_nxt;
    logic             cs_n_q, cs_n_nxt;
    logic             load_raw;

    logic             sdo_s1, sdo_s2;
    logic [ADC_W-1:0] raw_data;
    logic             raw_stb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sdo_s1 <= 1'b0;
            sdo_s2 <= 1'b0;
        end else begin
            sdo_s1 <= bus.adc_sdo;
            sdo_s2 <= sdo_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= WAIT;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            sclk_q  <= sclk_nxt;
            cs_n_q  <= cs_n_nxt;
        end
    end

    // Pin levels are computed from the next state and registered, so CS_n and
    // SCLK switch on the same edge as the state and never glitch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        sclk_nxt    = 1'b0;
        load_raw    = 1'b0;

        unique case (state)
            WAIT: begin
                if (cnt == WAIT_TC) begin
                    cnt_nxt   = '0;
                    state_nxt = SETUP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            SETUP: begin
                if (cnt == DIV_TC) begin
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            SHIFT: begin
                sclk_nxt = sclk_q;
                if (cnt == DIV_TC) begin
                    cnt_nxt = '0;
                    if (!sclk_q) begin
                        sclk_nxt  = 1'b1;
                        shreg_nxt = {shreg[ADC_W-2:0], sdo_s2};
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = DONE;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DONE: begin
                load_raw    = 1'b1;
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                state_nxt   = WAIT;
            end

            default: begin
                state_nxt = WAIT;
            end
        endcase

        cs_n_nxt = !((state_nxt == SETUP) || (state_nxt == SHIFT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_data <= '0;
            raw_stb  <= 1'b0;
        end else begin
            raw_stb <= load_raw;
            if (load_raw) begin
                raw_data <= shreg;
            end
        end
    end

    assign bus.adc_cs_n = cs_n_q;
    assign bus.adc_sclk = sclk_q;
    assign bus.busy     = ~cs_n_q;

`ifdef ADC_AVG4_EN
    logic [ADC_W-1:0] avg_data;
    logic             avg_stb;

    adc_avg4 u_avg4 (
        .clk      (clk),
        .reset    (reset),
        .raw_data (raw_data),
        .raw_stb  (raw_stb),
        .avg_data (avg_data),
        .avg_stb  (avg_stb)
    );

    assign bus.adc_data   = avg_data;
    assign bus.data_valid = avg_stb;
`else
    assign bus.adc_data   = raw_data;
    assign bus.data_valid = raw_stb;
`endif

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: default-timing instance plus a
// CLK_DIV=4 / CONV_WAIT=1 instance for phase measurement.
module tb_adc_serial_reader;

`ifdef ADC_AVG4_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    adc_serial_reader_if bus ();
    adc_serial_reader_if bus_f ();

    adc_serial_reader #(.CLK_DIV(25), .CONV_WAIT(1000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    adc_serial_reader #(.CLK_DIV(4), .CONV_WAIT(1)) dut_f (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f)
    );

    assign bus_f.adc_sdo = 1'b1;

    // ADC model: MSB on CS_n fall, next bit on each SCLK fall.
    logic [7:0] adc_word = 8'h00;
    logic [7:0] adc_sh   = 8'h00;
    bit         armed    = 1'b1;

    always @(posedge bus.adc_cs_n or negedge bus.adc_cs_n or negedge bus.adc_sclk) begin
        if (bus.adc_cs_n === 1'b1) begin
            armed <= 1'b1;
        end else if (armed) begin
            adc_sh <= adc_word;
            armed  <= 1'b0;
        end else begin
            adc_sh <= {adc_sh[6:0], 1'b0};
        end
    end

    assign bus.adc_sdo = adc_sh[7];

    // cyc = number of rising edges since the last reset release
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int         mon_valid_total = 0;
    int         mon_hold_viol   = 0;
    logic [7:0] mon_prev        = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.data_valid === 1'b1) mon_valid_total <= mon_valid_total + 1;
            if (bus.data_valid !== 1'b1 && bus.adc_data !== mon_prev) mon_hold_viol <= mon_hold_viol + 1;
        end
        mon_prev <= bus.adc_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cs_fall(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int n = 0; n < 1500 && !ok; n++) begin
            @(negedge clk);
            if (bus.adc_cs_n === 1'b0) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic measure_sclk(input int stop_after, output int first, output int cnt, output int bad_sp);
        int   last;
        logic prev;
        bit   done;
        first  = 0;
        cnt    = 0;
        bad_sp = 0;
        last   = 0;
        done   = 1'b0;
        prev   = bus.adc_sclk;
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk);
            if (prev === 1'b0 && bus.adc_sclk === 1'b1) begin
                if (cnt == 0) first = cyc;
                else if (cyc - last != 50) bad_sp++;
                last = cyc;
                cnt++;
                if (cnt == stop_after) done = 1'b1;
            end
            prev = bus.adc_sclk;
            if (bus.adc_cs_n === 1'b1) done = 1'b1;
        end
    endtask

    task automatic wait_valid(output int at, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        at = 0;
        d  = 8'h00;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                d  = bus.adc_data;
            end
        end
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_raw;
        logic [7:0] exp_avg;
        bit         reset_first;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k, at, first_rise, nrise, bad, v0, h0;
        logic [7:0] d, expd;
        bit         ok;
        int         c0, c1, r1, lastr, lastf, fr, fhb, flb, fv;
        logic       pc, ps;
        bit         got;

        tbl[0]  = '{8'hA5, 8'hA5, 8'h29, 1'b0};
        tbl[1]  = '{8'h00, 8'h00, 8'h29, 1'b0};
        tbl[2]  = '{8'hFF, 8'hFF, 8'h69, 1'b0};
        tbl[3]  = '{8'h10, 8'h10, 8'h04, 1'b1};
        tbl[4]  = '{8'h20, 8'h20, 8'h0C, 1'b0};
        tbl[5]  = '{8'h30, 8'h30, 8'h18, 1'b0};
        tbl[6]  = '{8'h40, 8'h40, 8'h28, 1'b0};
        tbl[7]  = '{8'hFF, 8'hFF, 8'h63, 1'b0};
        tbl[8]  = '{8'hFF, 8'hFF, 8'h9B, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 8'hCF, 1'b0};
        tbl[10] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};

        adc_word = tbl[0].word;
        repeat (3) @(negedge clk);
        check("rst_cs_n", bus.adc_cs_n, 1);
        check("rst_sclk", bus.adc_sclk, 0);
        check("rst_data", bus.adc_data, 0);
        check("rst_valid", bus.data_valid, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b1;
        k = 0;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].reset_first) begin
                // abort a frame in the 4th SCLK high phase
                wait_cs_fall(at, ok);
                check("mid_cs_seen", ok, 1);
                measure_sclk(4, first_rise, nrise, bad);
                check("mid_rises", nrise, 4);
                repeat (10) @(negedge clk);
                check("mid_sclk_high", bus.adc_sclk, 1);
                reset = 1'b0;
                #1;
                check("mid_rst_cs_n", bus.adc_cs_n, 1);
                check("mid_rst_sclk", bus.adc_sclk, 0);
                check("mid_rst_data", bus.adc_data, 0);
                check("mid_rst_busy", bus.busy, 0);
                repeat (3) @(negedge clk);
                adc_word = tbl[i].word;
                reset = 1'b1;
                k = 0;
            end

            adc_word = tbl[i].word;
`ifdef ADC_AVG4_EN
            expd = tbl[i].exp_avg;
`else
            expd = tbl[i].exp_raw;
`endif
            #1;
            v0 = mon_valid_total;
            h0 = mon_hold_viol;

            if (k == 0) begin
                wait_cs_fall(at, ok);
                check("cs_fall_seen", ok, 1);
                check("cs_fall_cycle", at, 1000);
                check("busy_in_frame", bus.busy, 1);
                measure_sclk(9, first_rise, nrise, bad);
                check("sclk_first_rise", first_rise, 1050);
                check("sclk_rises", nrise, 8);
                check("sclk_spacing_bad", bad, 0);
            end

            wait_valid(at, d, ok);
            check("valid_seen", ok, 1);
            check("valid_cycle", at, 1426 * (k + 1) + LAT);
            check("data", d, expd);
            repeat (3) @(negedge clk);
            #1;
            check("valid_low_after", bus.data_valid, 0);
            check("valid_count", mon_valid_total - v0, 1);
            check("hold_violations", mon_hold_viol - h0, 0);
            k++;
        end

        // fast instance: phase lengths and frame period
        got = 1'b0;
        c0  = 0;
        pc  = bus_f.adc_cs_n;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (pc === 1'b1 && bus_f.adc_cs_n === 1'b0) begin
                got = 1'b1;
                c0  = cyc;
            end
            pc = bus_f.adc_cs_n;
        end
        check("fast_cs_seen", got, 1);
        check("fast_busy", bus_f.busy, 1);

        ps = bus_f.adc_sclk;
        got = 1'b0;
        fr = 0; fhb = 0; flb = 0; fv = 0; r1 = 0; lastr = 0; lastf = 0; c1 = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (bus_f.data_valid === 1'b1) fv++;
            if (ps === 1'b0 && bus_f.adc_sclk === 1'b1) begin
                if (fr == 0) r1 = cyc;
                else if (cyc - lastf != 4) flb++;
                lastr = cyc;
                fr++;
            end
            if (ps === 1'b1 && bus_f.adc_sclk === 1'b0) begin
                if (cyc - lastr != 4) fhb++;
                lastf = cyc;
            end
            ps = bus_f.adc_sclk;
            if (pc === 1'b1 && bus_f.adc_cs_n === 1'b0) begin
                got = 1'b1;
                c1  = cyc;
            end
            pc = bus_f.adc_cs_n;
        end
        check("fast_first_rise", r1 - c0, 8);
        check("fast_rises", fr, 8);
        check("fast_high_bad", fhb, 0);
        check("fast_low_bad", flb, 0);
        check("fast_period", c1 - c0, 70);
        check("fast_valid_count", fv, 1);
        check("fast_data", bus_f.adc_data, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
